// File: rtl/transmisor_teclado_ps2.sv
// PS/2 host-to-device transmitter: request-to-send, 11-edge frame with odd parity,
// device ACK check and a watchdog on the device clock.
module transmisor_teclado_ps2 #(
  parameter int T_INHIBIT = 10000,
  parameter int T_TIMEOUT = 200000,
  parameter int CNT_W     = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2clk,
  inout  wire        ps2data,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_error_tick
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_REL,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(T_INHIBIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(T_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_next;
  logic [7:0]       filt_reg;
  logic             filt_val, filt_next;
  logic             data_meta, data_sync;
  logic [8:0]       packet, packet_next;
  logic [3:0]       n, n_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ack_bad, ack_next;
  logic             clk_low, data_low;
  logic             fall_edge;
  logic             wd_active;

  // A device clock level only counts once eight consecutive samples agree.
  always_comb begin
    filt_next = filt_val;
    if (filt_reg == 8'hFF)
      filt_next = 1'b1;
    else if (filt_reg == 8'h00)
      filt_next = 1'b0;
  end

  assign fall_edge = filt_val & ~filt_next;
  assign wd_active = (state == S_START) || (state == S_DATA) ||
                     (state == S_STOP)  || (state == S_WAIT_REL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      filt_reg  <= 8'h00;
      filt_val  <= 1'b0;
      data_meta <= 1'b0;
      data_sync <= 1'b0;
      packet    <= 9'h000;
      n         <= 4'd0;
      cnt       <= '0;
      ack_bad   <= 1'b0;
    end else begin
      state     <= state_next;
      filt_reg  <= {ps2clk, filt_reg[7:1]};
      filt_val  <= filt_next;
      data_meta <= ps2data;
      data_sync <= data_meta;
      packet    <= packet_next;
      n         <= n_next;
      cnt       <= cnt_next;
      ack_bad   <= ack_next;
    end
  end

  always_comb begin
    state_next    = state;
    packet_next   = packet;
    n_next        = n;
    cnt_next      = cnt;
    ack_next      = ack_bad;
    clk_low       = 1'b0;
    data_low      = 1'b0;
    tx_idle       = 1'b0;
    tx_done_tick  = 1'b0;
    tx_error_tick = 1'b0;

    case (state)
      S_IDLE: begin
        tx_idle = 1'b1;
        if (wr_ps2) begin
          packet_next = {~^din, din};
          cnt_next    = INHIBIT_LOAD;
          state_next  = S_RTS;
        end
      end
      S_RTS: begin
        clk_low = 1'b1;
        if (cnt == '0)
          state_next = S_START;
        else
          cnt_next = cnt - CNT_ONE;
      end
      S_START: begin
        data_low = 1'b1;
        if (fall_edge) begin
          state_next = S_DATA;
          n_next     = 4'd8;
        end
      end
      S_DATA: begin
        data_low = ~packet[0];
        if (fall_edge) begin
          if (n != 4'd0) begin
            packet_next = {1'b0, packet[8:1]};
            n_next      = n - 4'd1;
          end else begin
            state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (fall_edge) begin
          ack_next   = data_sync;
          state_next = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (filt_val && data_sync)
          state_next = S_DONE;
      end
      S_DONE: begin
        tx_done_tick  = 1'b1;
        tx_error_tick = ack_bad;
        cnt_next      = '0;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // A device edge always beats watchdog expiry in the same cycle.
    if (wd_active) begin
      if (fall_edge) begin
        cnt_next = '0;
      end else if (cnt == TIMEOUT_MAX) begin
        cnt_next      = '0;
        clk_low       = 1'b0;
        data_low      = 1'b0;
        tx_error_tick = 1'b1;
        state_next    = S_IDLE;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end
  end

  assign ps2clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2data = data_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_transmisor_teclado_ps2.sv
// Bench for transmisor_teclado_ps2: a behavioural PS/2 keyboard clocks frames out of
// the host and the received bits are compared against din plus odd parity.
module tb_transmisor_teclado_ps2;

  localparam int T_INHIBIT = 100;
  localparam int T_TIMEOUT = 2000;
  localparam int HALF      = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  wire        ps2clk;
  wire        ps2data;
  logic       tx_idle, tx_done_tick, tx_error_tick;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;
  int both_seen = 0;
  int idle_tick = 0;

  logic snap_pre_data, snap_clk, snap_data, snap_idle, snap_done, snap_err;

  assign ps2clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = dev_data_low ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2data);

  always #5 clk = ~clk;

  transmisor_teclado_ps2 #(
    .T_INHIBIT(T_INHIBIT),
    .T_TIMEOUT(T_TIMEOUT),
    .CNT_W(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_error_tick(tx_error_tick)
  );

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_seen <= done_seen + 1;
    if (tx_error_tick === 1'b1) err_seen <= err_seen + 1;
    if (tx_done_tick === 1'b1 && tx_error_tick === 1'b1) both_seen <= both_seen + 1;
    if ((tx_done_tick === 1'b1 || tx_error_tick === 1'b1) && tx_idle === 1'b1)
      idle_tick <= idle_tick + 1;
  end

  // Keyboard model: waits out the inhibit, checks the start bit, then clocks 11 edges,
  // reading each host bit just before releasing the clock.
  task automatic device_frame(input int glitch_bit, input int reset_bit, input bit nack,
                              input bit silent, output logic [8:0] rx, output bit start_ok,
                              output bit stop_ok, output int low_cycles, output bit aborted);
    int t;
    rx = '0; start_ok = 0; stop_ok = 0; low_cycles = 0; aborted = 0; t = 0;
    @(negedge clk);
    while (ps2clk !== 1'b0 && t < 500) begin @(negedge clk); t++; end
    if (ps2clk !== 1'b0) begin aborted = 1; return; end
    while (ps2clk === 1'b0 && low_cycles < 1000) begin low_cycles++; @(negedge clk); end
    start_ok = (ps2data === 1'b0);
    if (silent) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && !nack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < 9) rx[i] = ps2data;
      else if (i == 9) stop_ok = (ps2data === 1'b1);
      dev_clk_low = 1'b0;
      if (i == 10) dev_data_low = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (i == glitch_bit && c == 20) dev_clk_low = 1'b1;
        if (i == glitch_bit && c == 23) dev_clk_low = 1'b0;
        if (i == reset_bit && c == 20) begin
          snap_pre_data = ps2data;
          #2 reset = 1'b0;
          #1;
          snap_clk = ps2clk; snap_data = ps2data; snap_idle = tx_idle;
          snap_done = tx_done_tick; snap_err = tx_error_tick;
          aborted = 1;
          return;
        end
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input bit nack,
                           input int glitch_bit, input bit late_wr);
    logic [8:0] rx, exp_frame;
    bit sok, stk, ab;
    int low, t, d0, e0, b0, i0;
    exp_frame = {(($countones(d) % 2) == 0) ? 1'b1 : 1'b0, d};
    d0 = done_seen; e0 = err_seen; b0 = both_seen; i0 = idle_tick;
    fork
      device_frame(glitch_bit, -1, nack, 1'b0, rx, sok, stk, low, ab);
      begin
        @(negedge clk); din = d; wr_ps2 = 1'b1;
        @(negedge clk); wr_ps2 = 1'b0;
        if (late_wr) begin
          repeat (400) @(negedge clk);
          din = 8'hAA; wr_ps2 = 1'b1;
          @(negedge clk); wr_ps2 = 1'b0;
        end
      end
    join
    t = 0;
    while (tx_idle !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    checks++; if (ab !== 1'b0) begin errors++; $display("[TB] FAIL %s device_saw_rts got aborted=%0b want 0", name, ab); end
    checks++; if (low !== T_INHIBIT) begin errors++; $display("[TB] FAIL %s inhibit_len got %0d want %0d", name, low, T_INHIBIT); end
    checks++; if (sok !== 1'b1) begin errors++; $display("[TB] FAIL %s start_bit got %0b want 1", name, sok); end
    checks++; if (rx[7:0] !== exp_frame[7:0]) begin errors++; $display("[TB] FAIL %s data_byte got %h want %h", name, rx[7:0], exp_frame[7:0]); end
    checks++; if (rx[8] !== exp_frame[8]) begin errors++; $display("[TB] FAIL %s parity got %b want %b", name, rx[8], exp_frame[8]); end
    checks++; if (stk !== 1'b1) begin errors++; $display("[TB] FAIL %s stop_bit got %0b want 1", name, stk); end
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("[TB] FAIL %s done_ticks got %0d want 1", name, done_seen - d0); end
    checks++; if (err_seen - e0 !== int'(nack)) begin errors++; $display("[TB] FAIL %s error_ticks got %0d want %0d", name, err_seen - e0, nack); end
    checks++; if (both_seen - b0 !== int'(nack)) begin errors++; $display("[TB] FAIL %s same_cycle_ticks got %0d want %0d", name, both_seen - b0, nack); end
    checks++; if (idle_tick - i0 !== 0) begin errors++; $display("[TB] FAIL %s tick_in_idle got %0d want 0", name, idle_tick - i0); end
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("[TB] FAIL %s idle_after got %b want 1", name, tx_idle); end
    checks++; if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin errors++; $display("[TB] FAIL %s lines_released got clk=%b data=%b want 1 1", name, ps2clk, ps2data); end
    if (late_wr) begin
      t = 0;
      while (tx_idle === 1'b1 && ps2clk === 1'b1 && t < 150) begin @(negedge clk); t++; end
      checks++; if (t !== 150) begin errors++; $display("[TB] FAIL %s late_wr_ignored got idle_cycles=%0d want 150", name, t); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got %b want 1", tx_idle); end
    checks++; if (tx_done_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", tx_done_tick); end
    checks++; if (tx_error_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", tx_error_tick); end
    checks++; if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin errors++; $display("[TB] FAIL reset_lines got clk=%b data=%b want 1 1", ps2clk, ps2data); end
    reset = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_set_leds();
    run_frame("set_leds_ED", 8'hED, 1'b0, -1, 1'b0);
    run_frame("byte_01", 8'h01, 1'b0, -1, 1'b0);
  endtask

  task automatic test_nack();
    run_frame("nack", 8'h5A, 1'b1, -1, 1'b0);
  endtask

  task automatic test_glitch();
    run_frame("glitch", 8'hC3, 1'b0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("ignored_wr", 8'h3C, 1'b0, -1, 1'b1);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 5; k++)
      run_frame("random", 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1, 1'b0);
  endtask

  task automatic test_timeout();
    logic [8:0] rx;
    bit sok, stk, ab;
    int low, n, d0, e0;
    d0 = done_seen; e0 = err_seen;
    fork
      device_frame(-1, -1, 1'b0, 1'b1, rx, sok, stk, low, ab);
      begin
        @(negedge clk); din = 8'h77; wr_ps2 = 1'b1;
        @(negedge clk); wr_ps2 = 1'b0;
      end
    join
    n = 0;
    while (tx_error_tick !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (sok !== 1'b1) begin errors++; $display("[TB] FAIL timeout_start_bit got %0b want 1", sok); end
    checks++; if (n < T_TIMEOUT - 5 || n > T_TIMEOUT + 3) begin errors++; $display("[TB] FAIL timeout_latency got %0d want about %0d", n, T_TIMEOUT - 1); end
    @(negedge clk);
    checks++; if (tx_idle !== 1'b1) begin errors++; $display("[TB] FAIL timeout_idle got %b want 1", tx_idle); end
    checks++; if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin errors++; $display("[TB] FAIL timeout_lines got clk=%b data=%b want 1 1", ps2clk, ps2data); end
    repeat (2) @(negedge clk);
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("[TB] FAIL timeout_no_done got %0d want 0", done_seen - d0); end
    checks++; if (err_seen - e0 !== 1) begin errors++; $display("[TB] FAIL timeout_error_ticks got %0d want 1", err_seen - e0); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] rx;
    logic [7:0] d;
    bit sok, stk, ab;
    int low, d0;
    d = 8'($urandom) & 8'hEF;
    d0 = done_seen;
    fork
      device_frame(-1, 4, 1'b0, 1'b0, rx, sok, stk, low, ab);
      begin
        @(negedge clk); din = d; wr_ps2 = 1'b1;
        @(negedge clk); wr_ps2 = 1'b0;
      end
    join
    checks++; if (snap_pre_data !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_bit4_driven got %b want 0", snap_pre_data); end
    checks++; if (snap_data !== 1'b1 || snap_clk !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_lines got clk=%b data=%b want 1 1", snap_clk, snap_data); end
    checks++; if (snap_idle !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_idle got %b want 1", snap_idle); end
    checks++; if (snap_done !== 1'b0 || snap_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ticks got done=%b err=%b want 0 0", snap_done, snap_err); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (tx_idle !== 1'b1 || ps2clk !== 1'b1 || ps2data !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_after got idle=%b clk=%b data=%b want 1 1 1", tx_idle, ps2clk, ps2data); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_done got %0d want 0", done_seen - d0); end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_nack();
    test_glitch();
    test_back_to_back();
    test_timeout();
    test_random_frames();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_time_limit got running want finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/transmisor_teclado_ps2.md
Name: transmisor_teclado_ps2

Overview:
- PS/2 host-to-device transmitter. Sends one command byte from the FPGA to the keyboard, e.g. 8'hED set-LEDs followed by the LED mask.
- Sits beside the existing PS/2 receiver on the same ps2clk/ps2data lines.
- tx_idle gates the receiver's rx_en so the receiver ignores frames we send.
- Lines are open-collector: the block drives 0 or releases to Z, never drives 1.

Parameters:
- T_INHIBIT, 10000: clk cycles ps2clk is held low for request-to-send (100 us at 100 MHz).
- T_TIMEOUT, 200000: watchdog limit, in clk cycles, between device falling edges (2 ms at 100 MHz).
- CNT_W, 18: width of the shared inhibit/watchdog counter; must hold max(T_INHIBIT, T_TIMEOUT).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state.
- wr_ps2  in  1  start-transmit strobe, sampled on rising clk.
- din  in  8  byte to send; latched when wr_ps2 is accepted.
- ps2clk  inout  1  PS/2 clock; driven 0 or Z.
- ps2data  inout  1  PS/2 data; driven 0 or Z.
- tx_idle  out  1  1 when in idle; drives the receiver's rx_en.
- tx_done_tick  out  1  one-cycle pulse at end of a completed frame.
- tx_error_tick  out  1  one-cycle pulse on NACK or timeout.

Behaviour:
- Reset (async, reset=0):
  - state=idle, tx_idle=1, both ticks 0.
  - ps2clk=Z and ps2data=Z immediately, including mid-frame.
  - Counter 0; clock filter register 0.
- Clock filter:
  - 8-bit shift register samples ps2clk each clk.
  - Filtered value becomes 1 when all 8 samples are 1, 0 when all 8 are 0, otherwise holds.
  - fall_edge = filtered value was 1 on the previous cycle and is 0 now. Glitches shorter than 8 cycles are never edges.
  - ps2data is sampled raw, synchronised through 2 flops.
- Packet: latched on accept as {parity, din}, where parity = ~^din (odd parity).
- FSM:
  - idle: wr_ps2=1 latches the packet, loads counter=T_INHIBIT-1, goes to rts. tx_idle drops and ps2clk is driven 0 on the next cycle. wr_ps2 in any other state is ignored.
  - rts: ps2clk=0, ps2data=Z, counter decrements. At counter=0: go to start.
  - start: ps2data=0 (start bit), ps2clk=Z, watchdog running. On fall_edge: go to data, n=8, watchdog cleared.
  - data: ps2data = 0 if packet[0]=0, else Z. On fall_edge with n≠0: shift packet right, n=n-1. On fall_edge with n=0 (parity has been presented): go to stop.
  - stop: ps2data=Z (stop bit). On fall_edge (11th edge): sample ps2data into ack_bad (1 = NACK), go to wait_rel.
  - wait_rel: both lines Z. When both lines read 1: go to done.
  - done: tx_done_tick=1 for one cycle; tx_error_tick=ack_bad on the same cycle; go to idle.
- Frame content: 9 bits on the data line after the start bit, d0..d7 LSB first, then parity.
- Watchdog:
  - Active in start, data, stop and wait_rel.
  - Cleared on every fall_edge, increments otherwise.
  - At T_TIMEOUT-1: release both lines, tx_error_tick=1 for one cycle, no done tick, return to idle.
- Ticks are never asserted while in idle, apart from the exit cycle of done or timeout.
- Simultaneous fall_edge and watchdog expiry: the edge wins.

Test Plan (bench overrides T_INHIBIT=100, T_TIMEOUT=2000; device model clocks at 50-cycle half-period):
- din=8'hED, wr_ps2 pulse:
  - ps2clk held 0 for 100 cycles, then start bit 0.
  - Data bits 1,0,1,1,0,1,1,1, parity 1, stop Z.
  - Device ACKs low → tx_done_tick=1 for 1 cycle, tx_error_tick=0, tx_idle=1 afterwards.
- din=8'h01 → data 1,0,0,0,0,0,0,0, parity 0; model receives 8'h01 with a correct parity check.
- Device leaves ps2data high on the 11th edge (NACK) → tx_done_tick and tx_error_tick both pulse on the same cycle.
- Device never clocks after the start bit → after 2000 cycles both lines go Z, tx_error_tick=1, no done tick, tx_idle=1.
- Second wr_ps2 with din=8'hAA mid-frame → ignored; the frame on the wire is still the first byte.
- 3-cycle low glitch on ps2clk during data → no bit advance.
- reset=0 asserted during data bit 4 → lines Z in the same cycle, tx_idle=1, outputs return to reset values.
